// File: rtl/secant_iref_tuner_if.sv
// Handshake/bus bundle for secant_iref_tuner; slave modport is the tuner side.
interface secant_iref_tuner_if #(
  parameter int BUS_WIDTH = 10,
  parameter int MAX_ITER  = 16
);
  localparam int IW = $clog2(MAX_ITER + 1);

  logic                 start_i;
  logic [BUS_WIDTH-1:0] q_desired_i;
  logic [BUS_WIDTH-1:0] i_ref_setup_i;
  logic [BUS_WIDTH-1:0] q_measured_i;
  logic                 meas_valid_i;
  logic [BUS_WIDTH-1:0] i_ref_o;
  logic                 i_ref_valid_o;
  logic                 busy_o;
  logic                 converged_o;
  logic                 went_unstable_o;
  logic [IW-1:0]        iter_count_o;

  modport master (
    output start_i, q_desired_i, i_ref_setup_i, q_measured_i, meas_valid_i,
    input  i_ref_o, i_ref_valid_o, busy_o, converged_o, went_unstable_o, iter_count_o
  );

  modport slave (
    input  start_i, q_desired_i, i_ref_setup_i, q_measured_i, meas_valid_i,
    output i_ref_o, i_ref_valid_o, busy_o, converged_o, went_unstable_o, iter_count_o
  );
endinterface

// File: rtl/secant_iref_tuner.sv
// Closed-loop secant search for the current reference i_ref, with a multi-cycle restoring divider.
// Optional post-convergence plant tracking is enabled by defining SECANT_TRACK_EN.
module secant_iref_tuner #(
  parameter int BUS_WIDTH = 10,
  parameter int TOL       = 30,
  parameter int MAX_ITER  = 16
) (
  input logic                clk_i,
  input logic                rst_i,
  secant_iref_tuner_if.slave bus
);
  localparam int W    = BUS_WIDTH;
  localparam int NW   = 2 * W + 2;
  localparam int CW   = NW + 1;
  localparam int IW   = $clog2(MAX_ITER + 1);
  localparam int CNTW = $clog2(NW);

  localparam logic [3:0] ST_IDLE   = 4'd0;
  localparam logic [3:0] ST_DRV_A  = 4'd1;
  localparam logic [3:0] ST_WAIT_A = 4'd2;
  localparam logic [3:0] ST_DRV_B  = 4'd3;
  localparam logic [3:0] ST_WAIT_B = 4'd4;
  localparam logic [3:0] ST_DIV    = 4'd5;
  localparam logic [3:0] ST_DRV_C  = 4'd6;
  localparam logic [3:0] ST_WAIT_C = 4'd7;
  localparam logic [3:0] ST_CHECK  = 4'd8;
  localparam logic [3:0] ST_DONE   = 4'd9;
  localparam logic [3:0] ST_FAIL   = 4'd10;
`ifdef SECANT_TRACK_EN
  localparam logic [3:0] ST_TRACK  = 4'd11;
`endif

  localparam logic [W:0]      TOL_L    = (W + 1)'(TOL);
  localparam logic [IW-1:0]   MAX_L    = IW'(MAX_ITER);
  localparam logic [CNTW-1:0] CNT_LAST = CNTW'(NW - 1);
  localparam logic [W-1:0]    B0_DEF   = {{(W - 1){1'b1}}, 1'b0};

  function automatic logic [W-1:0] abs_diff(input logic [W-1:0] x, input logic [W-1:0] y);
    if (x >= y) return x - y;
    else        return y - x;
  endfunction

  logic [3:0]      state_q, state_d;
  logic [W-1:0]    a_q, a_d, b_q, b_d, c_q, c_d;
  logic [W-1:0]    fa_q, fa_d, fb_q, fb_d, fc_q, fc_d, qd_q, qd_d;
  logic [W-1:0]    i_ref_q, i_ref_d;
  logic            irv_q, irv_d, busy_q, busy_d, conv_q, conv_d, unst_q, unst_d;
  logic [IW-1:0]   iter_q, iter_d;
  logic [NW-1:0]   dvd_q, dvd_d, quo_q, quo_d;
  logic [W-1:0]    rem_q, rem_d;
  logic [W:0]      dvs_q, dvs_d;
  logic            neg_q, neg_d;
  logic [CNTW-1:0] cnt_q, cnt_d;

  logic [W-1:0]         op_a_s, op_b_s, op_fa_s, op_fb_s;
  logic signed [W:0]    err_s, span_s, den_s;
  logic signed [NW-1:0] num_s;
  logic [NW-1:0]        num_mag_s;
  logic [W:0]           den_mag_s;
  logic [W:0]           rem_sh_s;
  logic                 fits_s;
  logic [W-1:0]         rem_nx_s;
  logic signed [CW-1:0] quot_s, b_ext_s, c_full_s;
  logic [W-1:0]         c_clamp_s;
  logic                 load_div_s;

  // Operand selection: WAIT_B uses the incoming f_b, CHECK uses the post-shift pair.
  always_comb begin
    op_a_s  = a_q;
    op_b_s  = b_q;
    op_fa_s = fa_q;
    op_fb_s = fb_q;
    case (state_q)
      ST_WAIT_B: op_fb_s = bus.q_measured_i;
      ST_CHECK: begin
        op_a_s  = b_q;
        op_b_s  = c_q;
        op_fa_s = fb_q;
        op_fb_s = fc_q;
      end
      default: op_a_s = a_q;
    endcase
  end

  assign err_s     = {1'b0, op_fb_s} - {1'b0, qd_q};
  assign span_s    = {1'b0, op_b_s} - {1'b0, op_a_s};
  assign den_s     = {1'b0, op_fb_s} - {1'b0, op_fa_s};
  assign num_s     = NW'(err_s) * NW'(span_s);
  assign num_mag_s = num_s[NW-1] ? -num_s : num_s;
  assign den_mag_s = den_s[W] ? -den_s : den_s;

  // One restoring-divide step per DIV cycle, dividend consumed MSB first.
  assign rem_sh_s = {rem_q, dvd_q[NW-1]};
  assign fits_s   = rem_sh_s >= dvs_q;
  assign rem_nx_s = fits_s ? W'(rem_sh_s - dvs_q) : rem_sh_s[W-1:0];

  assign quot_s   = neg_q ? -$signed({1'b0, quo_q}) : $signed({1'b0, quo_q});
  assign b_ext_s  = $signed({{(CW - W){1'b0}}, b_q});
  assign c_full_s = b_ext_s - quot_s;

  // Clamp the secant estimate into the DAC range.
  always_comb begin
    if (c_full_s[CW-1])           c_clamp_s = {W{1'b0}};
    else if (|c_full_s[CW-2:W])   c_clamp_s = {W{1'b1}};
    else                          c_clamp_s = c_full_s[W-1:0];
  end

  // Search FSM next-state and datapath update.
  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    c_d        = c_q;
    fa_d       = fa_q;
    fb_d       = fb_q;
    fc_d       = fc_q;
    qd_d       = qd_q;
    i_ref_d    = i_ref_q;
    irv_d      = 1'b0;
    busy_d     = busy_q;
    conv_d     = conv_q;
    unst_d     = unst_q;
    iter_d     = iter_q;
    load_div_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.start_i) begin
          busy_d  = 1'b1;
          conv_d  = 1'b0;
          unst_d  = 1'b0;
          iter_d  = {IW{1'b0}};
          qd_d    = bus.q_desired_i;
          a_d     = {W{1'b0}};
          b_d     = (bus.i_ref_setup_i == {W{1'b0}}) ? B0_DEF : bus.i_ref_setup_i;
          state_d = ST_DRV_A;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_DRV_A: begin
        i_ref_d = a_q;
        irv_d   = 1'b1;
        state_d = ST_WAIT_A;
      end
      ST_WAIT_A: begin
        if (bus.meas_valid_i) begin
          fa_d    = bus.q_measured_i;
          state_d = ST_DRV_B;
        end else begin
          state_d = ST_WAIT_A;
        end
      end
      ST_DRV_B: begin
        i_ref_d = b_q;
        irv_d   = 1'b1;
        state_d = ST_WAIT_B;
      end
      ST_WAIT_B: begin
        if (bus.meas_valid_i) begin
          fb_d = bus.q_measured_i;
          if (bus.q_measured_i == fa_q) begin
            state_d = ST_FAIL;
          end else begin
            load_div_s = 1'b1;
            state_d    = ST_DIV;
          end
        end else begin
          state_d = ST_WAIT_B;
        end
      end
      ST_DIV: begin
        if (cnt_q == CNT_LAST) state_d = ST_DRV_C;
        else                   state_d = ST_DIV;
      end
      ST_DRV_C: begin
        c_d     = c_clamp_s;
        i_ref_d = c_clamp_s;
        irv_d   = 1'b1;
        iter_d  = iter_q + IW'(1);
        state_d = ST_WAIT_C;
      end
      ST_WAIT_C: begin
        if (bus.meas_valid_i) begin
          fc_d    = bus.q_measured_i;
          state_d = ST_CHECK;
        end else begin
          state_d = ST_WAIT_C;
        end
      end
      ST_CHECK: begin
        if ({1'b0, abs_diff(fc_q, qd_q)} < TOL_L) begin
          state_d = ST_DONE;
        end else if (iter_q == MAX_L) begin
          state_d = ST_FAIL;
        end else begin
          a_d  = b_q;
          fa_d = fb_q;
          b_d  = c_q;
          fb_d = fc_q;
          if (fc_q == fb_q) begin
            state_d = ST_FAIL;
          end else begin
            load_div_s = 1'b1;
            state_d    = ST_DIV;
          end
        end
      end
      ST_DONE: begin
        conv_d  = 1'b1;
        busy_d  = 1'b0;
`ifdef SECANT_TRACK_EN
        state_d = ST_TRACK;
`else
        state_d = ST_IDLE;
`endif
      end
      ST_FAIL: begin
        unst_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
`ifdef SECANT_TRACK_EN
      ST_TRACK: begin
        if (bus.start_i) begin
          busy_d  = 1'b1;
          conv_d  = 1'b0;
          unst_d  = 1'b0;
          iter_d  = {IW{1'b0}};
          qd_d    = bus.q_desired_i;
          a_d     = {W{1'b0}};
          b_d     = (bus.i_ref_setup_i == {W{1'b0}}) ? B0_DEF : bus.i_ref_setup_i;
          state_d = ST_DRV_A;
        end else if (bus.meas_valid_i && !({1'b0, abs_diff(bus.q_measured_i, qd_q)} < TOL_L)) begin
          busy_d  = 1'b1;
          conv_d  = 1'b0;
          iter_d  = {IW{1'b0}};
          a_d     = {W{1'b0}};
          b_d     = i_ref_q;
          state_d = ST_DRV_A;
        end else begin
          state_d = ST_TRACK;
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  // Divider operand load on DIV entry, otherwise advance one step per cycle.
  always_comb begin
    dvd_d = dvd_q;
    quo_d = quo_q;
    rem_d = rem_q;
    dvs_d = dvs_q;
    neg_d = neg_q;
    cnt_d = cnt_q;
    if (load_div_s) begin
      dvd_d = num_mag_s;
      dvs_d = den_mag_s;
      neg_d = num_s[NW-1] ^ den_s[W];
      quo_d = {NW{1'b0}};
      rem_d = {W{1'b0}};
      cnt_d = {CNTW{1'b0}};
    end else if (state_q == ST_DIV) begin
      dvd_d = {dvd_q[NW-2:0], 1'b0};
      quo_d = {quo_q[NW-2:0], fits_s};
      rem_d = rem_nx_s;
      cnt_d = cnt_q + CNTW'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
      fa_q    <= '0;
      fb_q    <= '0;
      fc_q    <= '0;
      qd_q    <= '0;
      i_ref_q <= '0;
      irv_q   <= 1'b0;
      busy_q  <= 1'b0;
      conv_q  <= 1'b0;
      unst_q  <= 1'b0;
      iter_q  <= '0;
      dvd_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      dvs_q   <= '0;
      neg_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      fa_q    <= fa_d;
      fb_q    <= fb_d;
      fc_q    <= fc_d;
      qd_q    <= qd_d;
      i_ref_q <= i_ref_d;
      irv_q   <= irv_d;
      busy_q  <= busy_d;
      conv_q  <= conv_d;
      unst_q  <= unst_d;
      iter_q  <= iter_d;
      dvd_q   <= dvd_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dvs_q   <= dvs_d;
      neg_q   <= neg_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.i_ref_o         = i_ref_q;
  assign bus.i_ref_valid_o   = irv_q;
  assign bus.busy_o          = busy_q;
  assign bus.converged_o     = conv_q;
  assign bus.went_unstable_o = unst_q;
  assign bus.iter_count_o    = iter_q;
endmodule
